// File: rtl/ifu_fetch.sv
// Instruction fetch stage and F/D pipeline register: owns the PC, computes next-PC with a
// branch delay slot. Optional fetch-address range/alignment checking under IFU_ADDR_CHECK_EN.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_3000,
    parameter logic [31:0] IM_BASE        = 32'h0000_3000,
    parameter int unsigned IM_DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_op_D,
    input  logic        br_cond_D,
    input  logic [31:0] jr_target_D,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc8_D,
    output logic        valid_D,
    output logic        fetch_err_D
);

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JREG   = 2'b11
    } npc_op_e;

    // Parameter sanity: a zero-sized or misaligned instruction memory makes no sense.
    if (IM_DEPTH_WORDS < 1 || IM_BASE[1:0] != 2'b00) begin : g_bad_im_params
        $error("ifu_fetch: IM_DEPTH_WORDS must be >= 1 and IM_BASE word aligned");
    end

    logic [31:0] pc_f_reg;
    logic [31:0] instr_d_reg;
    logic [31:0] pc_d_reg;
    logic        valid_d_reg;

    logic [31:0] pc_f_plus4;
    logic [31:0] pc_d_plus4;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] pc_f_next;
    logic [31:0] fetch_word;
    logic        fetch_fault;

    assign pc_f_plus4 = pc_f_reg + 32'd4;
    assign pc_d_plus4 = pc_d_reg + 32'd4;
    assign br_offset  = {{14{instr_d_reg[15]}}, instr_d_reg[15:0], 2'b00};
    assign br_target  = pc_d_plus4 + br_offset;
    assign j_target   = {pc_d_plus4[31:28], instr_d_reg[25:0], 2'b00};

    // Redirects come from the instruction sitting in D; the reset bubble never redirects.
    always_comb begin
        pc_f_next = pc_f_plus4;
        if (valid_d_reg) begin
            case (npc_op_e'(npc_op_D))
                NPC_BRANCH: pc_f_next = br_cond_D ? br_target : pc_f_plus4;
                NPC_JUMP:   pc_f_next = j_target;
                NPC_JREG:   pc_f_next = jr_target_D;
                default:    pc_f_next = pc_f_plus4;
            endcase
        end
    end

`ifdef IFU_ADDR_CHECK_EN
    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + 33'(4 * IM_DEPTH_WORDS);

    logic fetch_err_reg;

    assign fetch_fault = (pc_f_reg[1:0] != 2'b00)
                      || (pc_f_reg < IM_BASE)
                      || ({1'b0, pc_f_reg} >= IM_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_err_reg <= 1'b0;
        end else if (!stall) begin
            fetch_err_reg <= fetch_fault;
        end
    end

    assign fetch_err_D = fetch_err_reg;
`else
    assign fetch_fault = 1'b0;
    assign fetch_err_D = 1'b0;
`endif

    // A faulting fetch is replaced by a nop so decode never sees garbage.
    assign fetch_word = fetch_fault ? 32'h0000_0000 : imem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_reg    <= RESET_PC;
            instr_d_reg <= 32'h0000_0000;
            pc_d_reg    <= RESET_PC;
            valid_d_reg <= 1'b0;
        end else if (!stall) begin
            pc_f_reg    <= pc_f_next;
            instr_d_reg <= fetch_word;
            pc_d_reg    <= pc_f_reg;
            valid_d_reg <= 1'b1;
        end
    end

    assign imem_addr = pc_f_reg;
    assign instr_D   = instr_d_reg;
    assign pc_D      = pc_d_reg;
    assign pc8_D     = pc_d_reg + 32'd8;
    assign valid_D   = valid_d_reg;

endmodule
